// File: rtl/lsu_byte_serial.sv
// lsu_byte_serial
//   Byte-serial load/store unit. Takes one RV32I load or store request at a
//   time, checks it for an illegal width code or misalignment, then moves it
//   to/from a byte-wide synchronous memory as 1, 2 or 4 little-endian byte
//   transfers. Load data is assembled, sign/zero-extended and returned with a
//   single-cycle response pulse.
//
// Ports
//   clk, rst_n           clock (rising edge) and asynchronous active-low reset
//   req_valid/req_ready  request handshake; ready only while idle
//   req_write            1 = store, 0 = load
//   req_funct3           RV32I width code (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   req_addr             byte address; bits at and above ADDR_W are ignored
//   req_wdata            store data, low bytes used
//   resp_valid           one-cycle completion pulse
//   resp_rdata           extended load data (0 for stores and errors)
//   resp_err             misaligned address or illegal funct3
//   mem_addr/mem_re/mem_we/mem_wdata/mem_rdata
//                        byte memory interface, read data one cycle after mem_re
module lsu_byte_serial #(
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [2:0]        req_funct3,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_re,
   output logic              mem_we,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata
);

   typedef enum logic [1:0] {IDLE, XFER, DRAIN, RESP} state_t;

   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_t      state_reg;
   logic        write_reg;
   logic [2:0]  funct3_reg;
   logic [31:0] wdata_reg;      // store bytes still to be sent, next one in [7:0]
   logic [1:0]  idx_reg;        // byte index currently on the memory bus
   logic [1:0]  last_reg;       // index of the final byte (N-1)
   logic [31:0] data_reg;       // assembled load bytes
   logic        cap_valid_reg;  // a read was issued last cycle
   logic [1:0]  cap_idx_reg;    // byte lane that read belongs to

   logic [1:0]  req_last;
   logic        req_illegal;
   logic        req_misal;
   logic        req_err;
   logic [31:0] word_next;

   // Address bits above the memory window alias; kept only to mark them as
   // intentionally unused.
   logic        unused_addr_hi;
   assign unused_addr_hi = ^req_addr[31:ADDR_W];

   assign req_ready = (state_reg == IDLE);

   always_comb begin
      req_last = 2'd3;
      case (req_funct3[1:0])
         2'b00:   req_last = 2'd0;
         2'b01:   req_last = 2'd1;
         default: req_last = 2'd3;
      endcase
   end

   // Stores only know SB/SH/SW; loads additionally allow LBU/LHU.
   assign req_illegal = req_write ? (req_funct3[2] || (req_funct3[1:0] == 2'b11))
                                  : ((req_funct3[1:0] == 2'b11) || (req_funct3 == 3'b110));
   assign req_misal   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
   assign req_err     = req_illegal || req_misal;

   // Load word including the byte arriving on mem_rdata this cycle, so the
   // response can be formed on the same edge that captures the final byte.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         assign word_next[8*gi +: 8] = (cap_valid_reg && (cap_idx_reg == 2'(gi)))
                                       ? mem_rdata : data_reg[8*gi +: 8];
      end
   endgenerate

   function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [31:0] w);
      case (f3)
         3'b000:  return {{24{w[7]}}, w[7:0]};
         3'b001:  return {{16{w[15]}}, w[15:0]};
         3'b100:  return {24'd0, w[7:0]};
         3'b101:  return {16'd0, w[15:0]};
         default: return w;
      endcase
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         write_reg     <= 1'b0;
         funct3_reg    <= 3'd0;
         wdata_reg     <= 32'd0;
         idx_reg       <= 2'd0;
         last_reg      <= 2'd0;
         data_reg      <= 32'd0;
         cap_valid_reg <= 1'b0;
         cap_idx_reg   <= 2'd0;
         resp_valid    <= 1'b0;
         resp_rdata    <= 32'd0;
         resp_err      <= 1'b0;
         mem_addr      <= '0;
         mem_re        <= 1'b0;
         mem_we        <= 1'b0;
         mem_wdata     <= 8'd0;
      end else begin
         resp_valid    <= 1'b0;
         cap_valid_reg <= mem_re;
         cap_idx_reg   <= idx_reg;
         if (cap_valid_reg)
            data_reg <= word_next;

         case (state_reg)
            IDLE: begin
               if (req_valid) begin
                  write_reg  <= req_write;
                  funct3_reg <= req_funct3;
                  idx_reg    <= 2'd0;
                  last_reg   <= req_last;
                  if (req_err) begin
                     state_reg  <= RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_rdata <= 32'd0;
                  end else begin
                     state_reg <= XFER;
                     mem_addr  <= req_addr[ADDR_W-1:0];
                     mem_re    <= !req_write;
                     mem_we    <= req_write;
                     mem_wdata <= req_wdata[7:0];
                     wdata_reg <= req_wdata >> 8;
                  end
               end
            end
            XFER: begin
               if (idx_reg == last_reg) begin
                  mem_re <= 1'b0;
                  mem_we <= 1'b0;
                  if (write_reg) begin
                     state_reg  <= RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b0;
                     resp_rdata <= 32'd0;
                  end else begin
                     state_reg <= DRAIN;
                  end
               end else begin
                  idx_reg   <= idx_reg + 2'd1;
                  mem_addr  <= mem_addr + ADDR_ONE;
                  mem_wdata <= wdata_reg[7:0];
                  wdata_reg <= wdata_reg >> 8;
               end
            end
            DRAIN: begin
               state_reg  <= RESP;
               resp_valid <= 1'b1;
               resp_err   <= 1'b0;
               resp_rdata <= extend_load(funct3_reg, word_next);
            end
            RESP: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/lsu_byte_serial.md
Name: lsu_byte_serial

Overview:
Load/store unit that sits between the core's control FSM (READ_MEMORY / WRITE_MEMORY states) and a byte-wide synchronous memory.
- Accepts one RV32I load or store request at a time.
- Serialises it into 1, 2 or 4 little-endian byte transfers.
- Assembles and sign/zero-extends load data and returns a single-cycle response.
- Replaces direct multi-byte array indexing of memory in the core.

Parameters:
ADDR_W, 12, width of the byte address presented to memory; request address bits above ADDR_W are ignored (aliasing).

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  unit idle, can accept a request
req_write  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I width code: load 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store 000 SB, 001 SH, 010 SW
req_addr  in  32  effective byte address (ALU result)
req_wdata  in  32  store data; low bytes used
resp_valid  out  1  one-cycle pulse, transaction complete
resp_rdata  out  32  extended load data, valid with resp_valid; 0 for stores and errors
resp_err  out  1  valid with resp_valid; misaligned address or illegal funct3
mem_addr  out  ADDR_W  byte address to memory
mem_re  out  1  byte read strobe; mem_rdata is valid the cycle after
mem_we  out  1  byte write strobe, committed on the same edge
mem_wdata  out  8  byte to write
mem_rdata  in  8  read byte, fixed 1-cycle latency

Behaviour:
- Reset (async assert, sync deassert):
  - State = IDLE.
  - req_ready = 1; resp_valid = 0; resp_err = 0; resp_rdata = 0.
  - mem_re = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0.
- States: IDLE, XFER, DRAIN, RESP.
- req_ready = 1 only in IDLE. Accept on req_valid && req_ready (cycle T). addr, funct3, write and wdata are registered at T; request inputs are don't-care afterwards.
- N (byte count) = 1 for funct3[1:0]=00, 2 for 01, 4 for 10.
- Error check at accept:
  - funct3 ∉ legal set for the direction → illegal. Stores accept only 000/001/010; loads reject 011, 110, 111.
  - N=2 with addr[0]≠0 → misaligned.
  - N=4 with addr[1:0]≠0 → misaligned.
  - On error: IDLE → RESP. resp_valid=1 and resp_err=1 in T+1; no mem_re/mem_we ever asserted.
- XFER, byte index i = 0..N-1, one byte per cycle in cycles T+1..T+N:
  - mem_addr = (addr[ADDR_W-1:0] + i) mod 2^ADDR_W.
  - Load: mem_re=1. Store: mem_we=1, mem_wdata = wdata[8i+7:8i].
  - mem_re and mem_we are never both 1; both 0 outside XFER.
- Load capture: mem_rdata sampled the cycle after each issue into byte lane i of an internal 32-bit register.
  - After the last issue: XFER → DRAIN (cycle T+N+1) captures byte N-1.
  - DRAIN → RESP at T+N+2.
- Store: after the last byte, XFER → RESP at T+N+1.
- RESP lasts exactly 1 cycle, then → IDLE (req_ready=1 the following cycle). No back-to-back acceptance in RESP.
- resp_rdata extension from the captured N bytes:
  - LB: sign-extend bit 7. LBU: zero-extend from 8 bits.
  - LH: sign-extend bit 15. LHU: zero-extend from 16 bits.
  - LW: as is.
- resp_rdata/resp_err hold their values outside RESP until the next RESP overwrites them; consumers must qualify with resp_valid.
- Reset mid-transaction: immediate return to IDLE and outputs to reset values. Store bytes already written stay written (no rollback). No resp_valid is generated for the aborted request.
- req_valid held high while busy has no effect; the next request is taken only in IDLE.
- Address wrap: mem_addr arithmetic wraps at 2^ADDR_W. Aligned accesses never wrap inside one transaction.

Test Plan:
- Store then load: SW 0x8001_7F80 at addr 0x080 → mem[0x80..0x83] = 80,7F,01,80; mem_we high in exactly 4 cycles; resp_valid at T+5. LW 0x080 → resp_rdata 0x80017F80, resp_valid at T+6, resp_err 0.
- Extension: after the store above, LB 0x080 → 0xFFFFFF80; LBU 0x080 → 0x00000080; LH 0x082 → 0xFFFF8001; LHU 0x080 → 0x00007F80.
- Errors: LW addr 0x081 and SH addr 0x003 → resp_err 1 at T+1, resp_rdata 0, no mem strobes. Load funct3 011 → resp_err 1.
- Wrap/aliasing: ADDR_W=12, SB 0xAB at addr 0x0000_1FFF → mem[0xFFF] = 0xAB; LBU 0xFFF → 0x000000AB.
- Handshake: req_valid held high for 20 cycles with LW requests → exactly one acceptance per 7 cycles, req_ready low T+1..T+6.
- Reset mid-SW: assert rst_n low after 2 bytes written → only mem[addr], mem[addr+1] changed; req_ready=1 and resp_valid=0 immediately; the next LW completes normally.
